// File: rtl/intr_ack_sequencer_if.sv
// ---------------------------------------------------------------------------
// intr_ack_sequencer_if
//  Bundles every signal of the interrupt acknowledge sequencer except clk and
//  reset.
//
//  Modports:
//   slave  - the sequencer itself. It receives the resolver winner, the INTA
//            strobe, the mode/vector configuration and the EOI command. It
//            drives INT, the ISR latch strobe and level, the EOI clear mask,
//            and the data bus byte and enable.
//   master - the surrounding system (or a testbench) on the other side.
// ---------------------------------------------------------------------------
interface intr_ack_sequencer_if;
    logic [7:0]  interrupt_request_select;
    logic        inta_n;
    logic        mode_8086;
    logic        auto_eoi;
    logic [4:0]  vector_base;
    logic [10:0] call_address;
    logic        eoi_cmd;
    logic        eoi_specific;
    logic [2:0]  eoi_level;
    logic [7:0]  highest_level_in_service;
    logic        interrupt_to_cpu;
    logic        latch_in_service;
    logic [7:0]  interrupt;
    logic [7:0]  end_of_interrupt;
    logic [7:0]  data_out;
    logic        data_out_en;

    modport slave (
        input  interrupt_request_select, inta_n, mode_8086, auto_eoi,
               vector_base, call_address, eoi_cmd, eoi_specific, eoi_level,
               highest_level_in_service,
        output interrupt_to_cpu, latch_in_service, interrupt,
               end_of_interrupt, data_out, data_out_en
    );

    modport master (
        output interrupt_request_select, inta_n, mode_8086, auto_eoi,
               vector_base, call_address, eoi_cmd, eoi_specific, eoi_level,
               highest_level_in_service,
        input  interrupt_to_cpu, latch_in_service, interrupt,
               end_of_interrupt, data_out, data_out_en
    );
endinterface

// File: rtl/intr_ack_sequencer.sv
// ---------------------------------------------------------------------------
// intr_ack_sequencer
//  Sits between the priority resolver and the in-service register. It raises
//  INT for a pending winner and walks the INTA pulse sequence: two pulses in
//  x86 mode, three pulses for the 8080 CALL sequence. The first pulse strobes
//  the captured level into the ISR. The remaining pulses drive the vector or
//  CALL bytes onto the data bus. End-of-interrupt clear masks come from
//  automatic EOI and from OCW2 EOI commands.
//
//  Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; aborts any sequence in progress
//   bus    - intr_ack_sequencer_if.slave (request, inta_n, configuration,
//            EOI command in; INT, ISR strobe/level, EOI mask, data byte out)
//
//  Parameters:
//   SYNC_STAGES    - flops on inta_n ahead of edge detection (>= 2)
//   SPURIOUS_LEVEL - level returned when the request vanished at first INTA
// ---------------------------------------------------------------------------
module intr_ack_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    intr_ack_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PEND, ACK1, ACK2, ACK3} state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   inta_prev_reg;
    logic                   inta_fall;
    logic                   inta_rise;

    logic [7:0] cap_reg,       cap_next;
    logic [2:0] level_reg,     level_next;
    logic       spurious_reg,  spurious_next;
    logic       mode_reg,      mode_next;
    logic       int_reg,       int_next;
    logic       latch_reg,     latch_next;
    logic [7:0] interrupt_reg, interrupt_next;
    logic [7:0] eoi_reg,       eoi_next;
    logic [7:0] data_reg,      data_next;
    logic       en_reg,        en_next;

    logic [2:0] req_level;
    logic       aeoi_fire;
    logic [7:0] cmd_mask;

    // inta_n is asynchronous; it resets to the idle-high level so that no
    // phantom edge appears when reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg      <= '1;
            inta_prev_reg <= 1'b1;
        end else begin
            sync_reg[0] <= bus.inta_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            inta_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign inta_fall = inta_prev_reg & ~sync_reg[SYNC_STAGES-1];
    assign inta_rise = ~inta_prev_reg & sync_reg[SYNC_STAGES-1];

    // Binary level of the one-hot winner.
    always_comb begin
        req_level = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.interrupt_request_select[i]) begin
                req_level = 3'(i);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        cap_next       = cap_reg;
        level_next     = level_reg;
        spurious_next  = spurious_reg;
        mode_next      = mode_reg;
        int_next       = int_reg;
        latch_next     = 1'b0;
        interrupt_next = 8'h00;
        data_next      = data_reg;
        en_next        = en_reg;
        aeoi_fire      = 1'b0;

        // Every rising INTA ends a bus cycle, so the drive is released on it.
        if (inta_rise) begin
            en_next   = 1'b0;
            data_next = 8'h00;
        end

        case (state_reg)
            IDLE: begin
                int_next = 1'b0;
                if (bus.interrupt_request_select != 8'h00) begin
                    state_next = PEND;
                    int_next   = 1'b1;
                end
            end
            PEND: begin
                // The fall wins over a withdrawn request so that a request
                // vanishing right at the acknowledge becomes a spurious cycle.
                if (inta_fall) begin
                    state_next     = ACK1;
                    int_next       = 1'b0;
                    mode_next      = bus.mode_8086;
                    cap_next       = bus.interrupt_request_select;
                    if (bus.interrupt_request_select == 8'h00) begin
                        spurious_next = 1'b1;
                        level_next    = 3'(SPURIOUS_LEVEL);
                    end else begin
                        spurious_next  = 1'b0;
                        level_next     = req_level;
                        latch_next     = 1'b1;
                        interrupt_next = bus.interrupt_request_select;
                    end
                    if (!bus.mode_8086) begin
                        data_next = 8'hCD;
                        en_next   = 1'b1;
                    end
                end else if (bus.interrupt_request_select == 8'h00) begin
                    state_next = IDLE;
                    int_next   = 1'b0;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_next = ACK2;
                    en_next    = 1'b1;
                    if (mode_reg) begin
                        data_next = {bus.vector_base, level_reg};
                    end else begin
                        data_next = {bus.call_address[2:0], level_reg, 2'b00};
                    end
                end
            end
            ACK2: begin
                if (mode_reg) begin
                    if (inta_rise) begin
                        state_next = IDLE;
                        aeoi_fire  = bus.auto_eoi & ~spurious_reg;
                    end
                end else if (inta_fall) begin
                    state_next = ACK3;
                    data_next  = bus.call_address[10:3];
                    en_next    = 1'b1;
                end
            end
            ACK3: begin
                if (inta_rise) begin
                    state_next = IDLE;
                    aeoi_fire  = bus.auto_eoi & ~spurious_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // An OCW2 EOI and an automatic EOI in the same cycle are merged.
    always_comb begin
        cmd_mask = 8'h00;
        if (bus.eoi_cmd) begin
            cmd_mask = bus.eoi_specific ? (8'h01 << bus.eoi_level)
                                        : bus.highest_level_in_service;
        end
        eoi_next = cmd_mask | (aeoi_fire ? cap_reg : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cap_reg       <= 8'h00;
            level_reg     <= 3'd0;
            spurious_reg  <= 1'b0;
            mode_reg      <= 1'b0;
            int_reg       <= 1'b0;
            latch_reg     <= 1'b0;
            interrupt_reg <= 8'h00;
            eoi_reg       <= 8'h00;
            data_reg      <= 8'h00;
            en_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cap_reg       <= cap_next;
            level_reg     <= level_next;
            spurious_reg  <= spurious_next;
            mode_reg      <= mode_next;
            int_reg       <= int_next;
            latch_reg     <= latch_next;
            interrupt_reg <= interrupt_next;
            eoi_reg       <= eoi_next;
            data_reg      <= data_next;
            en_reg        <= en_next;
        end
    end

    assign bus.interrupt_to_cpu = int_reg;
    assign bus.latch_in_service = latch_reg;
    assign bus.interrupt        = interrupt_reg;
    assign bus.end_of_interrupt = eoi_reg;
    assign bus.data_out         = data_reg;
    assign bus.data_out_en      = en_reg;
endmodule
